gcd_arbiter: RTL

- Round-robin arbiter and sequencer that shares one `gcd` core between `N_REQ` requesters.
- Each requester presents operands over a valid/ready handshake. The block grants one requester, issues its operands to the core, waits for the result, and returns it to that requester only.
- Sits between the requester masters (APB wrapper instances, DMA-style clients) and a single `gcd` instance.
- One transaction is in flight at any time.

---
 rtl/gcd_arb_pkg.sv | 16 +
 rtl/gcd_rr_arbiter.sv | 34 +++
 rtl/gcd_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared types and limits for the gcd_arbiter block.
package gcd_arb_pkg;

  // Sequencer states; one transaction is in flight outside IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } gcd_arb_state_t;

  // Supported range of the requester count.
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 16;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index.
// The search starts at i_ptr and wraps modulo N_REQ, so N_REQ need not be a
// power of two.
module gcd_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_any
);

  // First requester found walking cyclically from the pointer wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(i_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!o_any && i_req[idx]) begin
        o_any       = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one gcd core between N_REQ valid/ready requesters.
// Round-robin grant in IDLE, operands issued in ISSUE, result awaited in
// WAIT, result returned only to the granted requester in RESP.
// Optional feature macro: GCD_ARB_ZERO_BYPASS_EN -- a request with a zero
// operand skips the core and answers a | b directly.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_gcd,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic [DATA_W-1:0]       o_gcd_a,
  output logic [DATA_W-1:0]       o_gcd_b,
  output logic                    o_gcd_valid,
  input  logic                    i_gcd_ready,
  input  logic [DATA_W-1:0]       i_gcd_result,
  input  logic                    i_gcd_valid,
  output logic                    o_gcd_ready,
  output logic                    o_busy
);

  gcd_arb_state_t    r_state;
  gcd_arb_state_t    w_state_next;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;

  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_any;
  logic              w_accept;
  logic              w_bypass;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [ID_W-1:0]   w_ptr_next;

  gcd_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req      (i_req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any)
  );

  // Operands of the currently granted requester.
  assign w_sel_a = i_req_a[int'(w_grant_id)*DATA_W +: DATA_W];
  assign w_sel_b = i_req_b[int'(w_grant_id)*DATA_W +: DATA_W];

`ifdef GCD_ARB_ZERO_BYPASS_EN
  // gcd(x,0) = x and gcd(0,0) = 0, so a | b is the answer without the core.
  assign w_bypass = (w_sel_a == '0) || (w_sel_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Pointer moves one past the winner, wrapping at N_REQ-1.
  assign w_ptr_next = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

  assign o_gcd_a   = r_a;
  assign o_gcd_b   = r_b;
  assign o_rsp_gcd = r_res;
  assign o_busy    = (r_state != ST_IDLE);

  // Next-state and handshake outputs; req_ready is held low during reset so
  // nothing is accepted while the block is being cleared.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    o_req_ready  = '0;
    o_rsp_valid  = '0;
    o_gcd_valid  = 1'b0;
    o_gcd_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst && w_any) begin
          o_req_ready  = w_grant;
          w_accept     = 1'b1;
          w_state_next = w_bypass ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_gcd_valid = 1'b1;
        if (i_gcd_ready) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        o_gcd_ready = 1'b1;
        if (i_gcd_valid) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid[r_id] = 1'b1;
        if (i_rsp_ready[r_id]) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, pointer and transaction latches.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    if (rst) begin
      // NOTE: operand and result registers are cleared too, so every output
      // reads 0 after reset rather than a stale in-flight transaction.
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_id  <= w_grant_id;
        r_ptr <= w_ptr_next;
        if (w_bypass) r_res <= w_sel_a | w_sel_b;
      end
      if (r_state == ST_WAIT && i_gcd_valid) r_res <= i_gcd_result;
    end
  end

endmodule
